expu_row_ctrl: RTL and testbench

- Sequencer for one pipelined exponential row. The row has a single enable, a single synchronous clear and NUM_REGS register stages, but no valid tracking.
- The block accepts a job of len_i elements through a valid/ready input stream. It drives the row's enable and clear, tracks per-stage valid bits and presents a valid/ready output stream with a last flag.
- Sits between the streamer/operand feeder and the row; the row data path itself is not instantiated inside this block.

---
 rtl/expu_pkg.sv | 12 +
 rtl/expu_row_ctrl.sv | 120 ++++++++++++
 tb/tb_expu_row_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/expu_pkg.sv
// Shared types for the exponential-row control path.
// The sequencer FSM states live here so the integrating top and the bench can see them.
package expu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } expu_ctrl_state_e;

endpackage

// File: rtl/expu_row_ctrl.sv
// Sequencer for one stall-all exponential row: accepts a job of len_i elements,
// drives the row enable/clear and tracks per-stage valid bits toward the output stream.
module expu_row_ctrl
  import expu_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 2,
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 out_last_o,
  output logic                 row_enable_o,
  output logic                 row_clear_o
);

  expu_ctrl_state_e     state_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] in_cnt_q;
  logic [LEN_WIDTH-1:0] out_cnt_q;
  logic [LEN_WIDTH-1:0] len_m1;

  logic in_room;
  logic stage_en;
  logic in_hs;
  logic out_hs;
  logic start_acc;
  logic out_valid;

  assign len_m1    = len_q - LEN_WIDTH'(1);
  assign in_room   = (state_q == RUN) && (in_cnt_q < len_q);
  assign stage_en  = ~out_valid | out_ready_i;
  assign in_hs     = in_valid_i & in_ready_o;
  assign out_hs    = out_valid & out_ready_i;
  assign start_acc = (state_q == IDLE) & start_i & ~clear_i;

  // The whole row moves or holds together, so a single enable gates every stage.
  generate
    if (NUM_REGS == 0) begin : g_comb
      assign out_valid  = in_valid_i & in_room;
      assign in_ready_o = out_ready_i & in_room;
    end else begin : g_pipe
      logic [NUM_REGS-1:0] vld_q;

      always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
          vld_q <= '0;
        end else if (stage_en) begin
          vld_q <= (vld_q << 1) | NUM_REGS'(in_hs);
        end
      end

      assign out_valid  = vld_q[NUM_REGS-1];
      assign in_ready_o = stage_en & in_room;
    end
  endgenerate

  // Abort and reset share one path: back to IDLE with no done pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q   <= IDLE;
      len_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      if (in_hs) begin
        in_cnt_q <= in_cnt_q + LEN_WIDTH'(1);
      end
      if (out_hs && busy_o) begin
        out_cnt_q <= out_cnt_q + LEN_WIDTH'(1);
      end

      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            len_q     <= len_i;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            state_q   <= (len_i == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          // With no register stages the final output leaves in the same cycle it enters.
          if (out_hs && out_last_o) begin
            state_q <= DONE;
          end else if (in_hs && (in_cnt_q == len_m1)) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_hs && out_last_o) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o       = (state_q == RUN) || (state_q == DRAIN);
  assign done_o       = (state_q == DONE);
  assign out_valid_o  = out_valid;
  assign out_last_o   = out_valid & (out_cnt_q == len_m1);
  assign row_enable_o = stage_en & ~rst_i;
  assign row_clear_o  = clear_i | start_acc | rst_i;

endmodule

// File: tb/tb_expu_row_ctrl.sv
// Bench for expu_row_ctrl: a two-stage instance and a zero-stage instance,
// with expected last flags queued at input acceptance and matched at output acceptance.
module tb_expu_row_ctrl;

  localparam int LW = 16;

  logic clk = 1'b0;
  logic rst;

  logic          a_clear, a_start, a_in_valid, a_out_ready;
  logic [LW-1:0] a_len;
  logic          a_busy, a_done, a_in_ready, a_out_valid, a_out_last, a_row_en, a_row_clr;

  logic          z_clear, z_start, z_in_valid, z_out_ready;
  logic [LW-1:0] z_len;
  logic          z_busy, z_done, z_in_ready, z_out_valid, z_out_last, z_row_en, z_row_clr;

  int checks   = 0;
  int failures = 0;
  bit sb_q[$];

  always #5 clk = ~clk;

  expu_row_ctrl #(.NUM_REGS(2), .LEN_WIDTH(LW)) dut_a (
    .clk_i(clk), .rst_i(rst), .clear_i(a_clear), .start_i(a_start), .len_i(a_len),
    .busy_o(a_busy), .done_o(a_done), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_last_o(a_out_last),
    .row_enable_o(a_row_en), .row_clear_o(a_row_clr)
  );

  expu_row_ctrl #(.NUM_REGS(0), .LEN_WIDTH(LW)) dut_z (
    .clk_i(clk), .rst_i(rst), .clear_i(z_clear), .start_i(z_start), .len_i(z_len),
    .busy_o(z_busy), .done_o(z_done), .in_valid_i(z_in_valid), .in_ready_o(z_in_ready),
    .out_valid_o(z_out_valid), .out_ready_i(z_out_ready), .out_last_o(z_out_last),
    .row_enable_o(z_row_en), .row_clear_o(z_row_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    {a_clear, a_start, a_in_valid, a_out_ready} = '0;
    {z_clear, z_start, z_in_valid, z_out_ready} = '0;
    a_len = '0;
    z_len = '0;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if ({a_busy, a_done, a_in_ready, a_out_valid, a_out_last, a_row_en, a_row_clr} !== 7'b0000001) begin
      failures++;
      $display("[TB] FAIL reset_a got=%b want=0000001",
               {a_busy, a_done, a_in_ready, a_out_valid, a_out_last, a_row_en, a_row_clr});
    end
    checks++;
    if ({z_busy, z_done, z_in_ready, z_out_valid, z_out_last, z_row_en, z_row_clr} !== 7'b0000001) begin
      failures++;
      $display("[TB] FAIL reset_z got=%b want=0000001",
               {z_busy, z_done, z_in_ready, z_out_valid, z_out_last, z_row_en, z_row_clr});
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_row_en, a_row_clr, z_row_en, z_row_clr} !== 4'b1010) begin
      failures++;
      $display("[TB] FAIL idle_after_reset got=%b want=1010", {a_row_en, a_row_clr, z_row_en, z_row_clr});
    end
  endtask

  task automatic test_basic();
    int in_idx = 0;
    int outs   = 0;
    bit got;
    logic [4:0] exp_v;
    tick();
    a_start = 1'b1; a_len = 16'd4; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_row_clr, a_busy} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL basic_start got=%b want=10", {a_row_clr, a_busy});
    end
    for (int c = 1; c <= 9; c++) begin
      tick();
      a_start = 1'b0;
      @(negedge clk);
      exp_v = {c <= 6, c == 7, c <= 4, c >= 3 && c <= 6, c == 6};
      checks++;
      if ({a_busy, a_done, a_in_ready, a_out_valid, a_out_last} !== exp_v) begin
        failures++;
        $display("[TB] FAIL basic_c%0d busy/done/ird/ov/last got=%b want=%b", c,
                 {a_busy, a_done, a_in_ready, a_out_valid, a_out_last}, exp_v);
      end
      if (a_in_valid && a_in_ready) begin sb_q.push_back(in_idx == 3); in_idx++; end
      if (a_out_valid && a_out_ready) begin
        outs++;
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL basic_sb got=unexpected_output want=none");
        end else begin
          got = sb_q.pop_front();
          if (a_out_last !== got) begin
            failures++;
            $display("[TB] FAIL basic_last got=%b want=%b", a_out_last, got);
          end
        end
      end
    end
    checks++;
    if (outs != 4 || sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL basic_count got=%0d pending=%0d want=4 pending=0", outs, sb_q.size());
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_stall();
    int in_idx = 0;
    int outs   = 0;
    int dones  = 0;
    bit got;
    tick();
    a_start = 1'b1; a_len = 16'd3; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 11; c++) begin
      tick();
      a_start = 1'b0;
      a_out_ready = !(c >= 4 && c <= 6);
      @(negedge clk);
      if (c >= 4 && c <= 6) begin
        checks++;
        if ({a_row_en, a_in_ready, a_out_valid, a_out_last} !== 4'b0010) begin
          failures++;
          $display("[TB] FAIL stall_c%0d en/ird/ov/last got=%b want=0010", c,
                   {a_row_en, a_in_ready, a_out_valid, a_out_last});
        end
      end
      if (a_done) dones++;
      if (a_in_valid && a_in_ready) begin sb_q.push_back(in_idx == 2); in_idx++; end
      if (a_out_valid && a_out_ready) begin
        outs++;
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL stall_sb got=unexpected_output want=none");
        end else begin
          got = sb_q.pop_front();
          if (a_out_last !== got) begin
            failures++;
            $display("[TB] FAIL stall_last got=%b want=%b", a_out_last, got);
          end
        end
      end
    end
    checks++;
    if (outs != 3 || dones != 1) begin
      failures++;
      $display("[TB] FAIL stall_count got outs=%0d dones=%0d want outs=3 dones=1", outs, dones);
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_zero_len();
    tick();
    a_start = 1'b1; a_len = '0; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_busy, a_in_ready, a_row_clr} !== 3'b001) begin
      failures++;
      $display("[TB] FAIL zero_start got=%b want=001", {a_busy, a_in_ready, a_row_clr});
    end
    for (int c = 1; c <= 3; c++) begin
      tick();
      a_start = 1'b0;
      @(negedge clk);
      checks++;
      if ({a_busy, a_in_ready, a_done} !== {2'b00, c == 1}) begin
        failures++;
        $display("[TB] FAIL zero_c%0d busy/ird/done got=%b want=%b", c,
                 {a_busy, a_in_ready, a_done}, {2'b00, c == 1});
      end
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_clear_drain();
    int in_idx = 0;
    int outs   = 0;
    int dones  = 0;
    bit got;
    tick();
    a_start = 1'b1; a_len = 16'd2; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 6; c++) begin
      tick();
      a_start = 1'b0;
      a_clear = (c == 4);
      @(negedge clk);
      if (c == 4) begin
        checks++;
        if ({a_busy, a_row_clr, a_out_valid} !== 3'b111) begin
          failures++;
          $display("[TB] FAIL clear_cycle busy/clr/ov got=%b want=111", {a_busy, a_row_clr, a_out_valid});
        end
      end else if (c >= 5) begin
        checks++;
        if ({a_busy, a_done, a_out_valid, a_in_ready} !== 4'b0000) begin
          failures++;
          $display("[TB] FAIL clear_after_c%0d busy/done/ov/ird got=%b want=0000", c,
                   {a_busy, a_done, a_out_valid, a_in_ready});
        end
      end
    end
    sb_q.delete();
    tick();
    a_start = 1'b1; a_len = 16'd2;
    @(negedge clk);
    for (int c = 1; c <= 12; c++) begin
      tick();
      a_start = 1'b0;
      @(negedge clk);
      if (a_done) dones++;
      if (a_in_valid && a_in_ready) begin sb_q.push_back(in_idx == 1); in_idx++; end
      if (a_out_valid && a_out_ready) begin
        outs++;
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL restart_sb got=unexpected_output want=none");
        end else begin
          got = sb_q.pop_front();
          if (a_out_last !== got) begin
            failures++;
            $display("[TB] FAIL restart_last got=%b want=%b", a_out_last, got);
          end
        end
      end
    end
    checks++;
    if (outs != 2 || dones != 1) begin
      failures++;
      $display("[TB] FAIL restart_count got outs=%0d dones=%0d want outs=2 dones=1", outs, dones);
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_nr0_random();
    int cnt    = 0;
    int in_idx = 0;
    int last_c = -1;
    bit exp_done = 1'b0;
    bit eov;
    bit got;
    tick();
    z_start = 1'b1; z_len = 16'd5;
    @(negedge clk);
    for (int c = 1; c <= 200; c++) begin
      tick();
      z_start     = 1'b0;
      z_in_valid  = (c > 100) ? 1'b1 : 1'($urandom_range(0, 1));
      z_out_ready = (c > 100) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      eov = z_in_valid && (cnt < 5);
      checks++;
      if (z_out_valid !== eov) begin
        failures++;
        $display("[TB] FAIL nr0_valid_c%0d got=%b want=%b", c, z_out_valid, eov);
      end
      checks++;
      if (z_in_ready !== (z_out_ready && cnt < 5)) begin
        failures++;
        $display("[TB] FAIL nr0_ready_c%0d got=%b want=%b", c, z_in_ready, z_out_ready && cnt < 5);
      end
      checks++;
      if (z_done !== exp_done) begin
        failures++;
        $display("[TB] FAIL nr0_done_c%0d got=%b want=%b", c, z_done, exp_done);
      end
      exp_done = 1'b0;
      if (eov && z_out_ready) begin
        sb_q.push_back(in_idx == 4);
        in_idx++;
        got = sb_q.pop_front();
        checks++;
        if (z_out_last !== got) begin
          failures++;
          $display("[TB] FAIL nr0_last_c%0d got=%b want=%b", c, z_out_last, got);
        end
        cnt++;
        if (cnt == 5) begin exp_done = 1'b1; last_c = c; end
      end
      if (last_c >= 0 && c == last_c + 1) break;
    end
    checks++;
    if (cnt != 5 || last_c < 0) begin
      failures++;
      $display("[TB] FAIL nr0_count got=%0d want=5", cnt);
    end
    z_in_valid = 1'b0;
    z_out_ready = 1'b0;
  endtask

  task automatic test_start_ignored();
    int in_idx = 0;
    int outs   = 0;
    bit got;
    tick();
    a_start = 1'b1; a_len = 16'd3; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 8; c++) begin
      tick();
      a_start = (c == 2);
      a_len   = (c == 2) ? 16'd7 : 16'd3;
      @(negedge clk);
      checks++;
      if ({a_busy, a_done} !== {c <= 5, c == 6}) begin
        failures++;
        $display("[TB] FAIL ignore_c%0d busy/done got=%b want=%b", c, {a_busy, a_done}, {c <= 5, c == 6});
      end
      if (a_in_valid && a_in_ready) begin sb_q.push_back(in_idx == 2); in_idx++; end
      if (a_out_valid && a_out_ready) begin
        outs++;
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL ignore_sb got=unexpected_output want=none");
        end else begin
          got = sb_q.pop_front();
          if (a_out_last !== got) begin
            failures++;
            $display("[TB] FAIL ignore_last got=%b want=%b", a_out_last, got);
          end
        end
      end
    end
    checks++;
    if (outs != 3) begin
      failures++;
      $display("[TB] FAIL ignore_count got=%0d want=3", outs);
    end
    a_start = 1'b0;
  endtask

  task automatic test_reset_mid();
    tick();
    a_start = 1'b1; a_len = 16'd4; a_in_valid = 1'b1; a_out_ready = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      a_start = 1'b0;
      rst = (c == 3 || c == 4);
      @(negedge clk);
      if (c == 4) begin
        checks++;
        if ({a_busy, a_done, a_in_ready, a_out_valid, a_out_last, a_row_en, a_row_clr} !== 7'b0000001) begin
          failures++;
          $display("[TB] FAIL midreset got=%b want=0000001",
                   {a_busy, a_done, a_in_ready, a_out_valid, a_out_last, a_row_en, a_row_clr});
        end
      end else if (c == 5) begin
        checks++;
        if ({a_busy, a_in_ready, a_out_valid, a_row_en, a_row_clr} !== 5'b00010) begin
          failures++;
          $display("[TB] FAIL midreset_release got=%b want=00010",
                   {a_busy, a_in_ready, a_out_valid, a_row_en, a_row_clr});
        end
      end
    end
    a_in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_len();
    test_clear_drain();
    test_nr0_random();
    test_start_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
